// File: rtl/mem_dump_reader.sv
// mem_dump_reader: debug-side initiator that reads a contiguous range of
// 32-bit words from the data memory and streams each word out as four
// bytes, least-significant byte first, over a valid/ready byte interface
// that feeds the UART transmitter.
//
// All outputs are registered. They are loaded from the next-state
// decision, so every output is already correct in the first cycle of the
// state it belongs to. For example, o_tx_valid is high exactly while the
// FSM sits in SEND, and an abort clears it on the same edge that returns
// the FSM to IDLE.
module mem_dump_reader #(
    parameter int NB_DATA_BUS = 32,
    parameter int NB_ADDRESS  = 8,
    parameter int NB_COUNT    = 7
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [NB_ADDRESS-1:0]  i_base_addr,
    input  logic [NB_COUNT-1:0]    i_n_words,
    input  logic                   i_abort,
    output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
    output logic                   o_mem_r_en,
    output logic [1:0]             o_mem_r_addressing,
    input  logic [NB_DATA_BUS-1:0] i_mem_r_data,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_CAPT = 3'd2,
        ST_SEND = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NB_ADDRESS-1:0]  r_addr;
    logic [NB_ADDRESS-1:0]  w_addr_next;
    logic [NB_COUNT-1:0]    r_cnt;
    logic [NB_COUNT-1:0]    w_cnt_next;
    logic [1:0]             r_idx;
    logic [1:0]             w_idx_next;
    logic [NB_DATA_BUS-1:0] r_word;
    logic [NB_DATA_BUS-1:0] w_word_next;
    logic                   r_mem_r_en;
    logic                   r_tx_valid;
    logic [7:0]             r_tx_data;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_handshake;
    logic                   w_base_low_unused;

    // The low two address bits are discarded: accesses are always word aligned.
    assign w_base_low_unused = ^i_base_addr[1:0];

    assign w_handshake = r_tx_valid & i_tx_ready;

    // Next-state and datapath-next computation for the dump sequencer.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_word_next  = r_word;

        case (r_state)
            ST_IDLE: begin
                // Abort has priority over start while idle.
                if (i_start && !i_abort) begin
                    w_addr_next = {i_base_addr[NB_ADDRESS-1:2], 2'b00};
                    w_cnt_next  = i_n_words;
                    if (i_n_words == {NB_COUNT{1'b0}}) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_REQ;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_state_next = ST_CAPT;
            end
            ST_CAPT: begin
                // Read data is valid on the edge that ends this cycle.
                w_word_next  = i_mem_r_data;
                w_idx_next   = 2'd0;
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_handshake) begin
                    if (r_idx == 2'd3) begin
                        w_state_next = ST_NEXT;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                    end
                end else begin
                    w_state_next = ST_SEND;
                end
            end
            ST_NEXT: begin
                // Address wraps modulo 2^NB_ADDRESS with no error.
                w_addr_next = r_addr + NB_ADDRESS'(4);
                w_cnt_next  = r_cnt - NB_COUNT'(1);
                if (r_cnt == NB_COUNT'(1)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Abort from any active state returns to idle without a done pulse.
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
        end else begin
            w_state_next = w_state_next;
        end
    end

    // State, datapath and registered outputs, all loaded from the next-state decision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= {NB_ADDRESS{1'b0}};
            r_cnt      <= {NB_COUNT{1'b0}};
            r_idx      <= 2'd0;
            r_word     <= {NB_DATA_BUS{1'b0}};
            r_mem_r_en <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_word     <= w_word_next;
            r_mem_r_en <= (w_state_next == ST_REQ);
            r_tx_valid <= (w_state_next == ST_SEND);
            r_busy     <= (w_state_next != ST_IDLE);
            r_done     <= (w_state_next == ST_DONE);
            if (w_state_next == ST_SEND) begin
                r_tx_data <= w_word_next[{w_idx_next, 3'b000} +: 8];
            end else begin
                r_tx_data <= 8'h00;
            end
        end
    end

    assign o_mem_r_addr       = r_addr;
    assign o_mem_r_en         = r_mem_r_en;
    assign o_mem_r_addressing = 2'b00;
    assign o_tx_data          = r_tx_data;
    assign o_tx_valid         = r_tx_valid;
    assign o_busy             = r_busy;
    assign o_done             = r_done;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Testbench for mem_dump_reader. The stimulus pushes the expected memory
// addresses, bytes and done pulses into queues. A monitor running on the
// falling clock edge pops and compares them as the DUT presents them.
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_base_addr;
    logic [6:0]  i_n_words;
    logic        i_abort;
    logic [7:0]  o_mem_r_addr;
    logic        o_mem_r_en;
    logic [1:0]  o_mem_r_addressing;
    logic [31:0] i_mem_r_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    logic [31:0] mem [0:63];
    logic [31:0] rd_q = 32'h0;

    logic [7:0]  exp_addr[$];
    logic [7:0]  exp_byte[$];
    logic        exp_done[$];

    int          errors = 0;
    int          checks = 0;

    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    mem_dump_reader #(
        .NB_DATA_BUS(32),
        .NB_ADDRESS (8),
        .NB_COUNT   (7)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (i_start),
        .i_base_addr       (i_base_addr),
        .i_n_words         (i_n_words),
        .i_abort           (i_abort),
        .o_mem_r_addr      (o_mem_r_addr),
        .o_mem_r_en        (o_mem_r_en),
        .o_mem_r_addressing(o_mem_r_addressing),
        .i_mem_r_data      (i_mem_r_data),
        .o_tx_data         (o_tx_data),
        .o_tx_valid        (o_tx_valid),
        .i_tx_ready        (i_tx_ready),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears on the edge after the request cycle.
    always @(posedge clk) begin
        if (o_mem_r_en) begin
            rd_q <= mem[o_mem_r_addr[7:2]];
        end
    end
    assign i_mem_r_data = rd_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares reads, bytes and done pulses against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_tx_valid && i_tx_ready) begin
                if (exp_byte.size() == 0) begin
                    chk("unexpected_tx_byte", {24'h0, o_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_byte.pop_front()});
                end
            end
            if (prev_stall) begin
                chk("stall_valid_held", {31'h0, o_tx_valid}, 32'h1);
                chk("stall_data_held", {24'h0, o_tx_data}, {24'h0, prev_data});
            end
            if (o_mem_r_en) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_mem_read", {24'h0, o_mem_r_addr}, 32'hFFFF_FFFF);
                end else begin
                    chk("mem_r_addr", {24'h0, o_mem_r_addr}, {24'h0, exp_addr.pop_front()});
                end
                chk("mem_r_addressing", {30'h0, o_mem_r_addressing}, 32'h0);
            end
            if (o_done) begin
                chk("done_expected", {31'h0, (exp_done.size() != 0)}, 32'h1);
                if (exp_done.size() != 0) begin
                    exp_done.pop_front();
                end
            end
            if (o_tx_valid && !o_busy) begin
                chk("valid_implies_busy", {31'h0, o_busy}, 32'h1);
            end
            prev_stall <= o_tx_valid && !i_tx_ready && !i_abort;
            prev_data  <= o_tx_data;
        end else begin
            prev_stall <= 1'b0;
            prev_data  <= 8'h00;
        end
    end

    // Issue one dump. bp=1 drives ready with the pattern 0,0,1 repeating.
    task automatic run_dump(input logic [7:0] base, input int n, input bit bp);
        logic [7:0]  a;
        logic [31:0] w;
        int          c;
        int          busy_drop;
        a = {base[7:2], 2'b00};
        for (int k = 0; k < n; k++) begin
            exp_addr.push_back(a);
            w = mem[a[7:2]];
            for (int b = 0; b < 4; b++) begin
                exp_byte.push_back(w[8*b +: 8]);
            end
            a = a + 8'd4;
        end
        exp_done.push_back(1'b1);
        i_tx_ready  = bp ? 1'b0 : 1'b1;
        i_base_addr = base;
        i_n_words   = 7'(n);
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        c         = 0;
        busy_drop = 0;
        while (!o_done && c < 1000) begin
            if (!o_busy) begin
                busy_drop++;
            end
            @(posedge clk);
            #1;
            c++;
            if (bp) begin
                i_tx_ready = ((c % 3) == 2);
            end
        end
        chk("done_within_budget", {31'h0, (c < 1000)}, 32'h1);
        if (!bp) begin
            chk("done_latency", 32'(c), 32'(7 * n));
        end
        chk("busy_until_done", 32'(busy_drop), 32'h0);
        chk("busy_during_done", {31'h0, o_busy}, 32'h1);
        @(posedge clk);
        #1;
        chk("idle_after_done", {31'h0, o_busy}, 32'h0);
        chk("done_one_cycle", {31'h0, o_done}, 32'h0);
        i_tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h0F1E_2D3C ^ (32'(i) * 32'h0103_0507);
        end
        mem[0]  = 32'h1122_3344;
        mem[1]  = 32'hAABB_CCDD;
        mem[63] = 32'h5566_7788;
        mem[8]  = 32'hDEAD_BEEF;
        mem[9]  = 32'h0102_0304;
        mem[10] = 32'hCAFE_F00D;

        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = 8'h00;
        i_n_words   = 7'd0;
        i_abort     = 1'b0;
        i_tx_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",       {31'h0, o_busy},     32'h0);
        chk("rst_done",       {31'h0, o_done},     32'h0);
        chk("rst_tx_valid",   {31'h0, o_tx_valid}, 32'h0);
        chk("rst_mem_r_en",   {31'h0, o_mem_r_en}, 32'h0);
        chk("rst_mem_r_addr", {24'h0, o_mem_r_addr}, 32'h0);
        chk("rst_tx_data",    {24'h0, o_tx_data},  32'h0);
        chk("rst_addressing", {30'h0, o_mem_r_addressing}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two words from 0x00: 44,33,22,11,DD,CC,BB,AA.
        run_dump(8'h00, 2, 1'b0);
        // Unaligned base 0x07 reads the word at 0x04.
        run_dump(8'h07, 1, 1'b0);
        // Backpressure with ready pattern 0,0,1.
        run_dump(8'h20, 3, 1'b1);
        // Address wrap 0xFC -> 0x00.
        run_dump(8'hFC, 2, 1'b0);
        // Zero words: no reads, no bytes, immediate done.
        run_dump(8'h40, 0, 1'b0);

        // Abort during the second byte of the first word of a 4-word dump.
        exp_addr.push_back(8'h10);
        exp_byte.push_back(mem[4][7:0]);
        i_tx_ready  = 1'b1;
        i_base_addr = 8'h10;
        i_n_words   = 7'd4;
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        c = 0;
        while (!o_tx_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("abort_first_valid_seen", {31'h0, o_tx_valid}, 32'h1);
        @(posedge clk);
        #1;
        i_tx_ready = 1'b0;
        i_abort    = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        chk("abort_busy",     {31'h0, o_busy},     32'h0);
        chk("abort_tx_valid", {31'h0, o_tx_valid}, 32'h0);
        chk("abort_mem_r_en", {31'h0, o_mem_r_en}, 32'h0);
        chk("abort_no_done",  {31'h0, o_done},     32'h0);
        i_tx_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_stays_idle", {31'h0, o_busy}, 32'h0);

        // Abort together with start while idle: start is ignored.
        i_base_addr = 8'h00;
        i_n_words   = 7'd1;
        i_start     = 1'b1;
        i_abort     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("abort_beats_start", {31'h0, o_busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // A new start after the abort works normally.
        run_dump(8'h10, 1, 1'b0);

        chk("left_addrs", 32'(exp_addr.size()), 32'h0);
        chk("left_bytes", 32'(exp_byte.size()), 32'h0);
        chk("left_dones", 32'(exp_done.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
